// File: rtl/clock_gate_ctrl.sv
// Clock-gate enable controller: one wake/idle FSM per gated domain, a round-robin
// turn-on arbiter with a stagger timer, and a registered debug force-on override.
//
// state  | meaning
// S_OFF  | domain gated, no request seen
// S_PEND | request seen, waiting for a turn-on grant
// S_WAKE | enable high, counting down WAKE_DELAY before ack
// S_ON   | clock running and acknowledged
// S_IDLE | request low, counting down IDLE_TIMEOUT before gating
module clock_gate_ctrl #(
   parameter int NUM_DOMAINS  = 4,
   parameter int WAKE_DELAY   = 2,
   parameter int IDLE_TIMEOUT = 16,
   parameter int STAGGER      = 4
) (
   input  logic                   sys_clk_i,
   input  logic                   sys_reset_n_i,
   input  logic [NUM_DOMAINS-1:0] req_i,
   input  logic                   force_on_i,
   output logic [NUM_DOMAINS-1:0] enable_o,
   output logic [NUM_DOMAINS-1:0] ack_o,
   output logic                   busy_o
);

   localparam int MAX_WS  = (WAKE_DELAY > STAGGER) ? WAKE_DELAY : STAGGER;
   localparam int MAX_CNT = (MAX_WS > IDLE_TIMEOUT) ? MAX_WS : IDLE_TIMEOUT;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int PTR_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_DELAY);
   localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_TIMEOUT);
   localparam logic [CNT_W-1:0] STG_LD  = CNT_W'(STAGGER - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      S_OFF  = 3'd0,
      S_PEND = 3'd1,
      S_WAKE = 3'd2,
      S_ON   = 3'd3,
      S_IDLE = 3'd4
   } dom_state_e;

   dom_state_e             state_q [NUM_DOMAINS];
   dom_state_e             state_d [NUM_DOMAINS];
   logic [CNT_W-1:0]       cnt_q   [NUM_DOMAINS];
   logic [CNT_W-1:0]       cnt_d   [NUM_DOMAINS];
   logic [CNT_W-1:0]       stg_q, stg_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic [NUM_DOMAINS-1:0] enable_q, enable_d;
   logic [NUM_DOMAINS-1:0] ack_q, ack_d;
   logic                   busy_q, busy_d;
   logic [NUM_DOMAINS-1:0] eligible;
   logic [NUM_DOMAINS-1:0] grant;
   logic                   grant_vld;
   logic [PTR_W-1:0]       idx;

   // PEND domains whose request already dropped are not offered a grant, so a
   // stagger slot is never spent on a domain that is about to return to OFF.
   always_comb begin
      eligible  = '0;
      grant     = '0;
      grant_vld = 1'b0;
      ptr_d     = ptr_q;
      stg_d     = stg_q;
      idx       = '0;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         eligible[i] = (state_q[i] == S_PEND) && req_i[i];
      end
      if (stg_q == '0) begin
         for (int off = 0; off < NUM_DOMAINS; off++) begin
            idx = PTR_W'((int'(ptr_q) + off) % NUM_DOMAINS);
            if (!grant_vld && eligible[idx]) begin
               grant[idx] = 1'b1;
               grant_vld  = 1'b1;
               ptr_d      = PTR_W'((int'(idx) + 1) % NUM_DOMAINS);
            end
         end
         if (grant_vld) stg_d = STG_LD;
      end else begin
         stg_d = stg_q - 1'b1;
      end
   end

   always_comb begin
      enable_d = '0;
      ack_d    = '0;
      busy_d   = 1'b0;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            S_OFF: begin
               if (req_i[i]) state_d[i] = S_PEND;
            end
            S_PEND: begin
               if (!req_i[i]) begin
                  state_d[i] = S_OFF;
               end else if (grant[i]) begin
                  state_d[i] = S_WAKE;
                  cnt_d[i]   = WAKE_LD;
               end
            end
            S_WAKE: begin
               if (cnt_q[i] == CNT_ONE) begin
                  state_d[i] = S_ON;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] - 1'b1;
               end
            end
            S_ON: begin
               if (!req_i[i]) begin
                  state_d[i] = S_IDLE;
                  cnt_d[i]   = IDLE_LD;
               end
            end
            S_IDLE: begin
               if (req_i[i]) begin
                  state_d[i] = S_ON;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_ONE) begin
                  state_d[i] = S_OFF;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] - 1'b1;
               end
            end
            default: begin
               state_d[i] = S_OFF;
               cnt_d[i]   = '0;
            end
         endcase
         // Outputs decode the next state so they are flops aligned with the FSM.
         enable_d[i] = (state_d[i] == S_WAKE) || (state_d[i] == S_ON) ||
                       (state_d[i] == S_IDLE);
         ack_d[i]    = (state_d[i] == S_ON) || (state_d[i] == S_IDLE);
         busy_d      = busy_d | (state_d[i] != S_OFF);
      end
      enable_d = enable_d | {NUM_DOMAINS{force_on_i}};
   end

   always_ff @(posedge sys_clk_i) begin
      if (!sys_reset_n_i) begin
         for (int i = 0; i < NUM_DOMAINS; i++) begin
            state_q[i] <= S_OFF;
            cnt_q[i]   <= '0;
         end
         stg_q    <= '0;
         ptr_q    <= '0;
         enable_q <= '0;
         ack_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_DOMAINS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         stg_q    <= stg_d;
         ptr_q    <= ptr_d;
         enable_q <= enable_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
      end
   end

   assign enable_o = enable_q;
   assign ack_o    = ack_q;
   assign busy_o   = busy_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed bench for clock_gate_ctrl at default parameters: reset, wake latency,
// staggered contention, idle gate-off, request pulses, force override, mid-flight reset.
module tb_clock_gate_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       force_on;
   logic [3:0] enable;
   logic [3:0] ack;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   clock_gate_ctrl #(
      .NUM_DOMAINS (4),
      .WAKE_DELAY  (2),
      .IDLE_TIMEOUT(16),
      .STAGGER     (4)
   ) dut (
      .sys_clk_i    (clk),
      .sys_reset_n_i(rst_n),
      .req_i        (req),
      .force_on_i   (force_on),
      .enable_o     (enable),
      .ack_o        (ack),
      .busy_o       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   int rise [4];
   int bad;
   logic [3:0] prev;

   initial begin
      rst_n    = 1'b0;
      req      = 4'b0001;
      force_on = 1'b0;

      // reset held with a live request
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_en_held", enable, 4'b0000);
      end
      chk("rst_ack", ack, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("wake_e1_en", enable, 4'b0000);
      chk("wake_e1_busy", busy, 1'b1);
      tick();
      chk("wake_e2_en", enable, 4'b0001);
      chk("wake_e2_ack", ack, 4'b0000);
      tick();
      chk("wake_e3_ack", ack, 4'b0000);
      tick();
      chk("wake_e4_ack", ack, 4'b0001);
      chk("wake_e4_busy", busy, 1'b1);

      // contention: all four request together, pointer at 0
      req = 4'b0000;
      do_reset();
      req  = 4'b1111;
      prev = 4'b0000;
      for (int b = 0; b < 4; b++) rise[b] = -1;
      for (int e = 0; e < 16; e++) begin
         tick();
         for (int b = 0; b < 4; b++) begin
            if (enable[b] && !prev[b]) rise[b] = e;
         end
         prev = enable;
      end
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("rr_rise_%0d", b), rise[b], 1 + 4 * b);
      end
      chk("rr_ack_all", ack, 4'b1111);

      // domain 2 idle gate-off after exactly 16 edges
      req = 4'b0000;
      do_reset();
      req = 4'b0100;
      repeat (4) tick();
      chk("d2_on_ack", ack, 4'b0100);
      req = 4'b0000;
      tick();
      chk("d2_idle_ack", ack, 4'b0100);
      repeat (15) tick();
      chk("d2_k15_en", enable, 4'b0100);
      chk("d2_k15_ack", ack, 4'b0100);
      tick();
      chk("d2_k16_en", enable, 4'b0000);
      chk("d2_k16_ack", ack, 4'b0000);
      chk("d2_k16_busy", busy, 1'b0);

      // re-request at cycle 10 of idle keeps the clock up
      req = 4'b0100;
      repeat (4) tick();
      chk("d2_reon_ack", ack, 4'b0100);
      req = 4'b0000;
      tick();
      repeat (9) tick();
      req = 4'b0100;
      bad = 0;
      for (int e = 0; e < 20; e++) begin
         tick();
         if (!ack[2] || !enable[2]) bad++;
      end
      chk("d2_rereq_no_drop", bad, 0);

      // one-cycle pulse on domain 1 while stagger is busy
      req = 4'b0000;
      do_reset();
      req = 4'b0001;
      tick();
      req = 4'b0011;
      tick();
      chk("pulse_e1_en", enable, 4'b0001);
      req = 4'b0001;
      bad = 0;
      for (int e = 0; e < 12; e++) begin
         tick();
         if (enable[1]) bad++;
      end
      chk("pulse_no_en1", bad, 0);
      chk("pulse_busy", busy, 1'b1);

      // pulse spanning the grant runs the full sequence
      req = 4'b0011;
      tick();
      chk("span_pend_en", enable, 4'b0001);
      tick();
      chk("span_wake_en", enable, 4'b0011);
      chk("span_wake_ack", ack, 4'b0001);
      req = 4'b0001;
      tick();
      chk("span_wake2_ack", ack, 4'b0001);
      tick();
      chk("span_on_ack", ack, 4'b0011);
      tick();
      chk("span_idle_ack", ack, 4'b0011);
      repeat (15) tick();
      chk("span_k15_en", enable, 4'b0011);
      tick();
      chk("span_k16_en", enable, 4'b0001);
      chk("span_k16_ack", ack, 4'b0001);

      // force override
      req = 4'b0000;
      do_reset();
      force_on = 1'b1;
      tick();
      chk("force_en", enable, 4'b1111);
      chk("force_ack", ack, 4'b0000);
      chk("force_busy", busy, 1'b0);
      force_on = 1'b0;
      tick();
      chk("force_off_en", enable, 4'b0000);

      // reset mid-WAKE
      do_reset();
      req = 4'b0001;
      tick();
      tick();
      chk("mw_wake_en", enable, 4'b0001);
      rst_n = 1'b0;
      tick();
      chk("mw_rst_en", enable, 4'b0000);
      chk("mw_rst_ack", ack, 4'b0000);
      chk("mw_rst_busy", busy, 1'b0);

      // reset mid-IDLE with pointer sitting at 1 beforehand
      rst_n = 1'b1;
      repeat (4) tick();
      chk("mi_on_ack", ack, 4'b0001);
      req = 4'b0000;
      repeat (6) tick();
      chk("mi_idle_en", enable, 4'b0001);
      rst_n = 1'b0;
      tick();
      chk("mi_rst_en", enable, 4'b0000);
      chk("mi_rst_ack", ack, 4'b0000);
      chk("mi_rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      req   = 4'b1111;
      tick();
      tick();
      chk("ptr_restart_e1", enable, 4'b0001);
      repeat (4) tick();
      chk("ptr_restart_e5", enable, 4'b0011);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
